// File: rtl/simd_result_fifo.sv
// First-word-fall-through result FIFO between the SIMD execute stage and its consumer.
// Define SIMD_RESULT_FIFO_DROP_CNT_EN to add a saturating 16-bit drop_count output.
module simd_result_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   input  logic [DATA_W-1:0]               in_data,
   output logic                            in_ready,
   output logic                            out_valid,
   output logic [DATA_W-1:0]               out_data,
   input  logic                            out_ready,
   output logic [$clog2(DEPTH):0]          count,
   output logic                            overflow,
`ifdef SIMD_RESULT_FIFO_DROP_CNT_EN
   output logic [15:0]                     drop_count,
`endif
   input  logic                            overflow_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   logic              drop;

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign in_ready  = (count != CNT_W'(DEPTH)) || out_ready;
   assign out_valid = (count != CNT_W'(0));
   assign out_data  = mem[rd_ptr];

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;
   assign drop = in_valid && !in_ready;

   // Storage carries no reset; out_data is meaningless while out_valid is low.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky drop flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef SIMD_RESULT_FIFO_DROP_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count <= '0;
      end else if (overflow_clr) begin
         drop_count <= drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/simd_result_fifo.md
SIMD_RESULT_FIFO -- requirements
Module: simd_result_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one SIMD result word (4 x 8-bit lanes).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; legal values are powers of two from 2 to 64.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 SHALL have port in_valid  input  1  upstream ALU result is present this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  ALU result word from the execute stage.
REQ-007 SHALL have port in_ready  output  1  the FIFO can accept a push this cycle.
REQ-008 SHALL have port out_valid  output  1  head entry is valid.
REQ-009 SHALL have port out_data  output  DATA_W  head entry, first-word-fall-through.
REQ-010 SHALL have port out_ready  input  1  downstream consumer takes the head this cycle.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port overflow  output  1  sticky flag: a push was dropped.
REQ-013 SHALL have port overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready.
REQ-015 SHALL drive in_ready = (count != DEPTH) || out_ready, combinationally.
REQ-016 SHALL drive out_valid = (count != 0), with out_data = mem[rd_ptr], without extra gating.
REQ-017 SHALL write in_data to mem[wr_ptr] on push; advance wr_ptr modulo DEPTH.
REQ-018 SHALL advance rd_ptr modulo DEPTH on pop; pointer wrap from DEPTH-1 to 0 needs no special handling.
REQ-019 SHALL have latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1), with no bypass when empty.
REQ-020 SHALL update count: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-021 When full, SHALL accept a push in the same cycle as a pop; count stays DEPTH.
REQ-022 When empty, SHALL ignore out_ready; a push in the same cycle is stored, and count becomes 1.
REQ-023 SHALL drop the word when in_valid=1 and in_ready=0, with no state change except overflow set to 1 at that edge.
REQ-024 SHALL clear overflow when overflow_clr=1; if a drop occurs in the same cycle, set wins.
REQ-025 SHALL preserve data order exactly (FIFO); no entry is lost or duplicated except per REQ-023.

Reset
REQ-026 While reset=0, SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, overflow=0, and hence out_valid=0 and in_ready=1.
REQ-027 SHALL NOT reset memory contents; out_data is don't-care while out_valid=0.
REQ-028 SHALL discard all entries when reset is asserted mid-operation; the first push after release appears as head.
REQ-029 SHALL make its first push possible at the first rising edge after reset deasserts.

Configuration
REQ-030 With macro SIMD_RESULT_FIFO_DROP_CNT_EN defined, SHALL add output drop_count (16 bits), reset to 0, incremented on each REQ-023 drop, saturating at 0xFFFF, and cleared by overflow_clr (a drop in the same cycle yields 1).
REQ-031 Without SIMD_RESULT_FIFO_DROP_CNT_EN, SHALL omit the drop_count port and its logic; all other behaviour is identical.

Verification
REQ-032 Bench SHALL check: reset, then push 0x01020304 with out_ready=0 -> the next cycle shows out_valid=1, out_data=0x01020304, count=1.
REQ-033 Bench SHALL check: push 8 words 0x0..0x7 with out_ready=0 -> count=8, in_ready=0; then drain -> data 0x0..0x7 in order, count=0, out_valid=0.
REQ-034 Bench SHALL check: full FIFO, in_valid=1 with in_data=0xAA, out_ready=0 -> word dropped, overflow=1 (drop_count=1 if enabled); pulse overflow_clr -> overflow=0.
REQ-035 Bench SHALL check: full FIFO, push 0xBB and pop together -> count stays 8; 0xBB emerges 8th after the pop.
REQ-036 Bench SHALL check: 20 cycles of continuous push and pop of incrementing data -> pointers wrap, output sequence matches input, count constant.
REQ-037 Bench SHALL check: reset=0 asserted asynchronously between edges with count=5 -> count=0 and out_valid=0 immediately; after release, push 0x55 -> head is 0x55.
